wb_bram_slave: RTL and testbench
================================

Name: wb_bram_slave

Overview:
Wishbone B4 responder that fronts an on-chip block RAM and serves the data-cache and non-cacheable bus masters. It supports classic cycles (CTI 000) and linear incrementing bursts (CTI 010 terminated by 111) with byte-select writes. After the first read beat, read bursts return one beat per clock. Accesses outside the decoded window get a one-cycle error response.

Parameters:
DW, 32, data width (multiple of 8)
AW, 32, bus address width
MW, 10, memory word-address width (depth = 2**MW words)
SW, DW/8, select width (localparam)
BASE_ADDR, 32'h00000000, window base
BASE_MASK, 32'hf0000000, decode mask; hit = ((i_wb_addr ^ BASE_ADDR) & BASE_MASK) == 0

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  synchronous reset, active-low
i_wb_cyc  in  1  cycle valid
i_wb_stb  in  1  strobe
i_wb_we  in  1  write enable
i_wb_addr  in  AW  byte address; word index = i_wb_addr[MW+1:2]
i_wb_data  in  DW  write data
i_wb_sel  in  SW  byte selects
i_wb_cti  in  3  cycle type: 000, 010 or 111
o_wb_data  out  DW  read data, valid while o_wb_ack=1 on a read
o_wb_ack  out  1  registered acknowledge
o_wb_err  out  1  registered error

Behaviour:
- Reset (i_rst_n=0 at an edge): o_wb_ack=0, o_wb_err=0, o_wb_data=0, state=IDLE, r_addr=0. RAM contents are not cleared. Reset overrides any in-flight beat.
- Memory: one synchronous-read/write port, one cycle read latency. Per-byte write enable = i_wb_sel.
- Request condition req = i_wb_cyc & i_wb_stb. Address bits [1:0] and bits above MW+1 inside the window are ignored.
- FSM states: IDLE, RD_WAIT, RD_ACK, WR_ACK, ERR.
- IDLE:
  - req & !hit -> ERR. o_wb_err=1 next cycle. No RAM access.
  - req & hit & we -> write RAM[word] with i_wb_data/i_wb_sel at this edge, then -> WR_ACK with o_wb_ack=1 next cycle.
  - req & hit & !we -> issue RAM read of word, r_addr<=word, -> RD_WAIT.
- RD_WAIT: o_wb_ack=1 and o_wb_data=RAM output; -> RD_ACK. First-beat latency is 2 cycles from stb.
- RD_ACK (the ack cycle):
  - If i_wb_cti==010 and req: prefetch RAM[r_addr+1], r_addr<=r_addr+1, and keep ack asserted next cycle (one beat per clock). r_addr wraps modulo 2**MW.
  - Else (000, 111, or req dropped): ack=0 next cycle, -> IDLE.
- WR_ACK: ack=1 for exactly one cycle, then -> IDLE. Write bursts therefore run 2 cycles per beat; each beat's address, data and sel are sampled fresh in IDLE.
- ERR: o_wb_err=1 for one cycle, then -> IDLE. Ack and err are never asserted together.
- If i_wb_cyc=0 in any non-IDLE state, the slave aborts: ack/err=0 next cycle and -> IDLE. A write already performed is not undone.
- o_wb_data holds its last value when ack=0. Reads and writes never overlap in flight.

Test Plan:
- Classic write then read: write addr 0x10, data 0xDEADBEEF, sel 1111, cti 000 -> ack 1 cycle after stb. Read of 0x10 -> ack 2 cycles after stb, o_wb_data=0xDEADBEEF.
- Byte-select write: RAM[0x10]=0xDEADBEEF, write 0x00000055 with sel 0001 -> readback 0xDEADBE55.
- Read burst: addrs 0x20..0x2C preloaded 1,2,3,4, cti 010,010,010,111 -> acks on cycles 2,3,4,5 with data 1,2,3,4; ack=0 on cycle 6.
- Wrap: MW=10, burst starting at word 1023 -> second beat returns RAM[0].
- Out-of-window access at 0x10000000 (read and write) -> o_wb_err=1 for one cycle, o_wb_ack=0, RAM unchanged.
- cyc dropped during RD_ACK of a burst, and i_rst_n=0 mid-burst -> ack=0 next cycle, state IDLE; the next classic read completes normally.

Source files
------------

// File: rtl/wb_bram_if.sv
// Wishbone B4 bus bundle between a master and the block-RAM responder.
interface wb_bram_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  localparam int SW = DW / 8;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] dat_w;
  logic [SW-1:0] sel;
  logic [2:0]    cti;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (output cyc, stb, we, addr, dat_w, sel, cti,
                  input  dat_r, ack, err);
  modport slave  (input  cyc, stb, we, addr, dat_w, sel, cti,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_bram_slave.sv
// Wishbone B4 block-RAM responder: classic cycles, incrementing read bursts at
// one beat per clock, byte-select writes, and a one-cycle error outside the window.
module wb_bram_slave #(
  parameter int          DW        = 32,
  parameter int          AW        = 32,
  parameter int          MW        = 10,
  parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [AW-1:0] BASE_MASK = 32'hf000_0000
) (
  input logic       i_clk,
  input logic       i_rst_n,
  wb_bram_if.slave  wb
);
  localparam int SW    = DW / 8;
  localparam int DEPTH = 2 ** MW;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_ACK, WR_ACK, ERR} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   r_addr, r_addr_d;
  logic            ack_p2, ack_d;
  logic            err_p2, err_d;
  logic [DW-1:0]   dat_p2;
  logic            dat_ld;

  logic [DW-1:0]   ram [DEPTH];
  logic [DW-1:0]   ram_dout_p1;
  logic            rd_en, wr_en;
  logic [MW-1:0]   rd_addr;

  logic            req, hit;
  logic [MW-1:0]   word;

  assign req  = wb.cyc & wb.stb;
  assign hit  = ((wb.addr ^ BASE_ADDR) & BASE_MASK) == '0;
  assign word = wb.addr[MW+1:2];

  // RD_WAIT and every continuing RD_ACK read one word ahead of the beat being
  // acknowledged, so the synchronous RAM can still deliver a beat per clock.
  always_comb begin
    state_d  = state_q;
    r_addr_d = r_addr;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_ld   = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = r_addr;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (!hit) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (wb.we) begin
            wr_en   = i_rst_n;
            ack_d   = 1'b1;
            state_d = WR_ACK;
          end else begin
            rd_en    = 1'b1;
            rd_addr  = word;
            r_addr_d = word;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!wb.cyc) begin
          state_d = IDLE;
        end else begin
          ack_d   = 1'b1;
          dat_ld  = 1'b1;
          rd_en   = 1'b1;
          rd_addr = r_addr + MW'(1);
          state_d = RD_ACK;
        end
      end
      RD_ACK: begin
        if (req && wb.cti == 3'b010) begin
          ack_d    = 1'b1;
          dat_ld   = 1'b1;
          r_addr_d = r_addr + MW'(1);
          rd_en    = 1'b1;
          rd_addr  = r_addr + MW'(2);
        end else begin
          state_d = IDLE;
        end
      end
      WR_ACK:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: RAM port, one cycle read latency
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (wb.sel[b]) ram[word][8*b +: 8] <= wb.dat_w[8*b +: 8];
      end
    end
    if (rd_en) ram_dout_p1 <= ram[rd_addr];
  end

  // Stage p2: registered bus response
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      r_addr  <= '0;
      ack_p2  <= 1'b0;
      err_p2  <= 1'b0;
      dat_p2  <= '0;
    end else begin
      state_q <= state_d;
      r_addr  <= r_addr_d;
      ack_p2  <= ack_d;
      err_p2  <= err_d;
      if (dat_ld) dat_p2 <= ram_dout_p1;
    end
  end

  assign wb.ack   = ack_p2;
  assign wb.err   = err_p2;
  assign wb.dat_r = dat_p2;
endmodule

// File: tb/tb_wb_bram_slave.sv
// Randomized bench for wb_bram_slave against a transaction-level memory model.
module tb_wb_bram_slave;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int MW    = 10;
  localparam int DEPTH = 1 << MW;
  localparam int NCYC  = 16384;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_bram_if #(.DW(DW), .AW(AW)) wb ();

  wb_bram_slave #(
    .DW(DW), .AW(AW), .MW(MW),
    .BASE_ADDR(32'h0000_0000), .BASE_MASK(32'hf000_0000)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .wb     (wb)
  );

  always #5 clk = ~clk;

  // cyc_n = number of rising edges so far; outputs seen after edge i live at index i
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [31:0] mem_m [DEPTH];
  bit          exp_ack [NCYC];
  bit          exp_err [NCYC];
  bit          exp_rd  [NCYC];
  bit          exp_rst [NCYC];
  logic [31:0] exp_dat [NCYC];
  logic [31:0] cap_dat [4];
  logic [31:0] last_dat = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a[31:28] == 4'h0;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [MW-1:0] w;
    w = a[MW+1:2];
    for (int b = 0; b < 4; b++)
      if (s[b]) mem_m[w][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Single compare process: every cycle, ack/err against the schedule; data
  // against the expected beat, or the held value when no read beat is due.
  always @(negedge clk) begin
    int i;
    i = cyc_n;
    if (checking && i < NCYC) begin
      if (exp_rst[i]) last_dat = '0;
      if (exp_rd[i])  last_dat = exp_dat[i];
      chk("ack", 32'(wb.ack), 32'(exp_ack[i]));
      chk("err", 32'(wb.err), 32'(exp_err[i]));
      if (!exp_ack[i] || exp_rd[i]) chk("dat", wb.dat_r, last_dat);
    end
  end

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.cti = 3'b000;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    @(posedge clk); #1;
    k = cyc_n;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1;
    wb.addr = a; wb.dat_w = d; wb.sel = s; wb.cti = 3'b000;
    if (in_win(a)) begin
      exp_ack[k+1] = 1'b1;
      m_write(a, d, s);
    end else begin
      exp_err[k+1] = 1'b1;
    end
    @(posedge clk); #1;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  // n beats starting at a; cut>0 stops at beat cut by dropping cyc, or by
  // pulsing reset when use_rst is set.
  task automatic do_read(input logic [31:0] a, input int n, input int cut, input bit use_rst);
    int k, last;
    logic [MW-1:0] w;
    @(posedge clk); #1;
    k = cyc_n;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = a;
    wb.dat_w = $urandom; wb.sel = 4'($urandom);
    wb.cti = (n > 1) ? 3'b010 : 3'b000;
    for (int j = 0; j < 4; j++) cap_dat[j] = '0;
    if (!in_win(a)) begin
      exp_err[k+1] = 1'b1;
      @(posedge clk); #1;
      wb.cyc = 1'b0; wb.stb = 1'b0;
      return;
    end
    w    = a[MW+1:2];
    last = (cut > 0) ? cut : n;
    for (int j = 1; j <= last; j++) begin
      exp_ack[k+1+j] = 1'b1;
      exp_rd[k+1+j]  = 1'b1;
      exp_dat[k+1+j] = mem_m[w + MW'(j-1)];
    end
    if (use_rst) exp_rst[k+2+last] = 1'b1;
    @(posedge clk); #1;
    for (int j = 1; j <= last; j++) begin
      @(posedge clk); #1;
      if (j == cut) begin
        if (use_rst) rst_n = 1'b0;
        else begin wb.cyc = 1'b0; wb.stb = 1'b0; end
      end else begin
        wb.cti = (j < n) ? 3'b010 : ((n > 1) ? 3'b111 : 3'b000);
      end
      @(negedge clk);
      cap_dat[j-1] = wb.dat_r;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; wb.cyc = 1'b0; wb.stb = 1'b0; wb.cti = 3'b000;
  endtask

  initial begin
    #(NCYC * 10 + 100);
    $display("FAIL watchdog: simulation exceeded %0d cycles", NCYC);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int op, n, cut;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.addr = '0;
    wb.dat_w = '0; wb.sel = '0; wb.cti = 3'b000;
    @(posedge clk); #1;
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int w = 0; w < DEPTH; w++) do_write(32'(w) << 2, $urandom, 4'hf);
    bus_idle(1);

    do_write(32'h10, 32'hDEADBEEF, 4'hf);
    do_read(32'h10, 1, 0, 0);
    chk("classic_rd", cap_dat[0], 32'hDEADBEEF);

    do_write(32'h10, 32'h0000_0055, 4'b0001);
    bus_idle(1);
    do_read(32'h10, 1, 0, 0);
    chk("bytesel_rd", cap_dat[0], 32'hDEADBE55);
    chk("bytesel_model", mem_m[4], 32'hDEADBE55);

    for (int j = 0; j < 4; j++) do_write(32'h20 + 32'(4*j), 32'(j+1), 4'hf);
    do_read(32'h20, 4, 0, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("burst%0d", j), cap_dat[j], 32'(j+1));

    do_write(32'hFFC, 32'hA5A5_0001, 4'hf);
    do_write(32'h000, 32'h5A5A_0002, 4'hf);
    do_read(32'hFFC, 2, 0, 0);
    chk("wrap0", cap_dat[0], 32'hA5A5_0001);
    chk("wrap1", cap_dat[1], 32'h5A5A_0002);

    do_write(32'h1000_0010, 32'h1234_5678, 4'hf);
    do_read(32'h1000_0010, 1, 0, 0);
    do_read(32'h10, 1, 0, 0);
    chk("err_ram_kept", cap_dat[0], 32'hDEADBE55);
    do_read(32'h0000_1013, 1, 0, 0);
    chk("alias_rd", cap_dat[0], 32'hDEADBE55);

    do_read(32'h20, 4, 2, 0);
    chk("abort_b0", cap_dat[0], 32'd1);
    chk("abort_b1", cap_dat[1], 32'd2);
    do_read(32'h24, 1, 0, 0);
    chk("after_abort", cap_dat[0], 32'd2);

    do_read(32'h20, 4, 3, 1);
    bus_idle(1);
    do_read(32'h28, 1, 0, 0);
    chk("after_reset", cap_dat[0], 32'd3);

    for (int t = 0; t < 300; t++) begin
      if (cyc_n > NCYC - 32) break;
      op = $urandom_range(0, 9);
      a  = $urandom & 32'h0FFF_FFFF;
      if ($urandom_range(0, 5) == 0) a[11:2] = 10'h3FE + 10'($urandom_range(0, 1));
      n  = $urandom_range(1, 4);
      if (op <= 3)      do_write(a, $urandom, 4'($urandom));
      else if (op <= 7) do_read(a, n, 0, 0);
      else if (op == 8) begin
        a = $urandom | 32'h1000_0000;
        if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'hf);
        else do_read(a, 1, 0, 0);
      end else begin
        cut = $urandom_range(1, n);
        do_read(a, n, cut, 1'($urandom_range(0, 1)));
      end
      bus_idle($urandom_range(0, 2));
    end

    bus_idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
